// File: rtl/button_led_pkg.sv
// Shared types, constants and helpers for the button-to-LED sequencer.
// The FSM state type, LED reset pattern and the button arbitration functions live here.
package button_led_pkg;

  localparam int NUM_BUTTONS = 8;
  localparam int BTN_IDX_W   = $clog2(NUM_BUTTONS);

  localparam logic [NUM_BUTTONS-1:0] LED_RESET = 8'h01;

  typedef enum logic {
    ROTATE = 1'b0,
    HOLD   = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic                 valid;
    logic [BTN_IDX_W-1:0] idx;
  } prio_t;

  function automatic logic [NUM_BUTTONS-1:0] one_hot(input logic [BTN_IDX_W-1:0] idx);
    logic [NUM_BUTTONS-1:0] v;
    // NOTE: blocking assignments are correct inside functions and combinational
    // code; they model ordered evaluation, not flop updates.
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Lowest set bit wins: scanning downward lets the lowest index overwrite last.
  function automatic prio_t prio_encode(input logic [NUM_BUTTONS-1:0] vec);
    prio_t r;
    r = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = BTN_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button input: 2-flop synchroniser followed by a consecutive-cycle
// debounce counter. Resets to 1 (released) since buttons are active-low.
module button_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic i_raw,
  output logic o_deb
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_deb   <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/button_led_sequencer.sv
// Drives the 8-LED module from 8 active-low buttons: debounce, press-edge detect,
// fixed-priority arbitration, and a ROTATE/HOLD sequencer stepped by a slow tick.
module button_led_sequencer
  import button_led_pkg::*;
#(
  parameter int STEP_W     = 25,
  parameter int DEB_CYCLES = 500000,
  parameter int HOLD_STEPS = 8
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [NUM_BUTTONS-1:0] Switch,
  output logic [NUM_BUTTONS-1:0] LED,
  output logic                   Press_valid,
  output logic [BTN_IDX_W-1:0]   Press_idx,
  output logic                   Hold
);

  localparam int HOLD_W = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;

  logic [NUM_BUTTONS-1:0] w_deb;
  logic [NUM_BUTTONS-1:0] w_fall;
  logic                   w_tick;
  prio_t                  w_prio;

  logic [NUM_BUTTONS-1:0] r_deb_q;
  logic [STEP_W-1:0]      r_step;
  seq_state_e             r_state;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [NUM_BUTTONS-1:0] r_led;
  logic                   r_press_valid;
  logic [BTN_IDX_W-1:0]   r_press_idx;
  logic                   r_hold;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    button_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .i_raw(Switch[g]),
      .o_deb(w_deb[g])
    );
  end

  // Press = debounced 1->0; releases are ignored.
  assign w_fall = r_deb_q & ~w_deb;
  assign w_prio = prio_encode(w_fall);
  assign w_tick = &r_step;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_deb_q <= '1;
      r_step  <= '0;
    end else begin
      r_deb_q <= w_deb;
      r_step  <= r_step + STEP_W'(1);
    end
  end

  // A press always wins over a coincident tick.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state       <= ROTATE;
      r_hold_cnt    <= '0;
      r_led         <= LED_RESET;
      r_press_valid <= 1'b0;
      r_press_idx   <= '0;
      r_hold        <= 1'b0;
    end else begin
      r_press_valid <= w_prio.valid;
      if (w_prio.valid) begin
        r_press_idx <= w_prio.idx;
        r_led       <= one_hot(w_prio.idx);
        r_hold_cnt  <= HOLD_W'(HOLD_STEPS);
        r_state     <= HOLD;
        r_hold      <= 1'b1;
      end else if (w_tick) begin
        if (r_state == ROTATE) begin
          r_led <= {r_led[0], r_led[NUM_BUTTONS-1:1]};
        end else if (r_hold_cnt == '0) begin
          r_state <= ROTATE;
          r_hold  <= 1'b0;
        end else begin
          r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        end
      end
    end
  end

  assign LED         = r_led;
  assign Press_valid = r_press_valid;
  assign Press_idx   = r_press_idx;
  assign Hold        = r_hold;

endmodule
